// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises PLL lock, holds every domain in reset for a
// qualified hold time, then releases the domains one at a time.
module reset_sequencer #(
  parameter int unsigned N_OUT       = 3,
  parameter int unsigned HOLD_CYCLES = 20,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             soft_rst_req,
  output logic [N_OUT-1:0] rst_n_out,
  output logic             ready,
  output logic [7:0]       restart_cnt
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          hcnt_q, hcnt_d;
  logic [CW-1:0]          scnt_q, scnt_d;
  logic [N_OUT-1:0]       out_d;
  logic                   ready_d;
  logic [7:0]             cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   abort;

  // Bring the asynchronous PLL lock into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign abort    = !locked_s || soft_rst_req;

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      hcnt_q      <= '0;
      scnt_q      <= '0;
      rst_n_out   <= '0;
      ready       <= 1'b0;
      restart_cnt <= '0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      scnt_q      <= scnt_d;
      rst_n_out   <= out_d;
      ready       <= ready_d;
      restart_cnt <= cnt_d;
    end
  end

  // Next-state logic; outputs are computed as next values so they leave flops.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    scnt_d  = scnt_q;
    out_d   = rst_n_out;
    ready_d = ready;
    cnt_d   = restart_cnt;
    unique case (state_q)
      S_HOLD: begin
        if (abort) begin
          hcnt_d = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          hcnt_d = '0;
          scnt_d = '0;
          out_d  = N_OUT'(1);
          if (N_OUT == 1) begin
            ready_d = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      S_RELEASE, S_RUN: begin
        if (abort) begin
          out_d   = '0;
          ready_d = 1'b0;
          hcnt_d  = '0;
          state_d = S_HOLD;
          if (restart_cnt != 8'hFF) cnt_d = restart_cnt + 8'd1;
        end else if (state_q == S_RELEASE) begin
          if (scnt_q == GAP_LAST) begin
            scnt_d = '0;
            // Shift a one in from the bottom: keeps the release thermometer-coded.
            out_d  = (rst_n_out << 1) | N_OUT'(1);
            if (&out_d) begin
              ready_d = 1'b1;
              state_d = S_RUN;
            end
          end else begin
            scnt_d = scnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

endmodule
